// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: segment encoding and standard VGA mode constants shared by the timing generator.
package vga_timing_pkg;
  typedef enum logic [1:0] {SEG_SYNC, SEG_BP, SEG_ACT, SEG_FP} seg_e;
  localparam int M800_H_SYNC = 120;
  localparam int M800_H_BP   = 64;
  localparam int M800_H_ACT  = 800;
  localparam int M800_H_FP   = 56;
  localparam int M800_V_SYNC = 6;
  localparam int M800_V_BP   = 23;
  localparam int M800_V_ACT  = 600;
  localparam int M800_V_FP   = 37;
  localparam bit M800_HS_POL = 1'b1;
  localparam bit M800_VS_POL = 1'b1;
  localparam int M640_H_SYNC = 96;
  localparam int M640_H_BP   = 48;
  localparam int M640_H_ACT  = 640;
  localparam int M640_H_FP   = 16;
  localparam int M640_V_SYNC = 2;
  localparam int M640_V_BP   = 33;
  localparam int M640_V_ACT  = 480;
  localparam int M640_V_FP   = 10;
  localparam bit M640_HS_POL = 1'b0;
  localparam bit M640_VS_POL = 1'b0;
endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_cnt: one raster axis counter with SYNC/BP/ACT/FP segment decode and active-area offset.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int CW   = 12,
  parameter int SYNC = 120,
  parameter int BP   = 64,
  parameter int ACT  = 800,
  parameter int FP   = 56
) (
  input  logic          clk_px,
  input  logic          rst,
  input  logic          adv,
  output logic [CW-1:0] cnt,
  output seg_e          seg,
  output logic          wrap,
  output logic [CW-1:0] coord
);
  localparam int TOT = SYNC + BP + ACT + FP;
  if (SYNC == 0 || BP == 0 || ACT == 0 || FP == 0 || TOT > (1 << CW)) begin : g_bad
    $error("vga_axis_cnt: zero-length segment or total exceeds counter range");
  end
  assign wrap  = adv && cnt == CW'(TOT - 1);
  assign seg   = cnt < CW'(SYNC) ? SEG_SYNC :
                 cnt < CW'(SYNC + BP) ? SEG_BP :
                 cnt < CW'(SYNC + BP + ACT) ? SEG_ACT : SEG_FP;
  assign coord = seg == SEG_ACT ? cnt - CW'(SYNC + BP) : '0;
  always_ff @(posedge clk_px)
    if (rst) cnt <= '0;
    else if (adv) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with frame-boundary run/stop;
// define VGA_TIMING_FRAME_CNT_EN to build the 16-bit frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW     = 12,
  parameter int H_SYNC = M800_H_SYNC,
  parameter int H_BP   = M800_H_BP,
  parameter int H_ACT  = M800_H_ACT,
  parameter int H_FP   = M800_H_FP,
  parameter int V_SYNC = M800_V_SYNC,
  parameter int V_BP   = M800_V_BP,
  parameter int V_ACT  = M800_V_ACT,
  parameter int V_FP   = M800_V_FP,
  parameter bit HS_POL = M800_HS_POL,
  parameter bit VS_POL = M800_VS_POL
) (
  input  logic          clk_px,
  input  logic          rst,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] px_x,
  output logic [CW-1:0] px_y,
  output logic          sof,
  output logic          sol,
  output logic          running,
  output logic [15:0]   frame_cnt
);
  logic [CW-1:0] h_cnt, v_cnt, h_xy, v_xy;
  seg_e h_seg, v_seg;
  logic h_wrap, v_wrap, frame_start;
  vga_axis_cnt #(.CW(CW), .SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)) u_h (
    .clk_px(clk_px), .rst(rst), .adv(running),
    .cnt(h_cnt), .seg(h_seg), .wrap(h_wrap), .coord(h_xy)
  );
  vga_axis_cnt #(.CW(CW), .SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)) u_v (
    .clk_px(clk_px), .rst(rst), .adv(h_wrap),
    .cnt(v_cnt), .seg(v_seg), .wrap(v_wrap), .coord(v_xy)
  );
  assign frame_start = running && h_cnt == '0 && v_cnt == '0;
  // v_wrap is the last cycle of a running frame: the only point where en is honoured while running
  always_ff @(posedge clk_px)
    if (rst) running <= 1'b0;
    else running <= running ? (v_wrap ? en : 1'b1) : en;
  always_ff @(posedge clk_px)
    if (rst || !running) begin
      hs   <= ~HS_POL;
      vs   <= ~VS_POL;
      de   <= 1'b0;
      px_x <= '0;
      px_y <= '0;
      sof  <= 1'b0;
      sol  <= 1'b0;
    end else begin
      hs   <= h_seg == SEG_SYNC ? HS_POL : ~HS_POL;
      vs   <= v_seg == SEG_SYNC ? VS_POL : ~VS_POL;
      de   <= h_seg == SEG_ACT && v_seg == SEG_ACT;
      px_x <= h_xy;
      px_y <= v_xy;
      sof  <= frame_start;
      sol  <= h_cnt == '0;
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc;
  always_ff @(posedge clk_px)
    if (rst) fc <= '0;
    else if (frame_start) fc <= fc + 16'd1;
  assign frame_cnt = fc;
`else
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized run/stop/reset stimulus checked every cycle against a linear-position raster model.
module tb_vga_timing_gen;
  localparam int CW = 8;
  localparam int HS = 2, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 1, VA = 5, VF = 2;
  localparam bit HP = 1'b0, VP = 1'b1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FR = HT * VT;
  logic clk_px = 0, rst = 1, en = 0;
  logic hs, vs, de, sof, sol, running;
  logic [CW-1:0] px_x, px_y;
  logic [15:0] frame_cnt;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 0;
  bit m_run = 0;
  int m_pos = 0;
  logic e_hs, e_vs, e_de, e_sof, e_sol, e_run;
  int e_x, e_y, e_fc = 0;
  vga_timing_gen #(
    .CW(CW), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF), .HS_POL(HP), .VS_POL(VP)
  ) dut (
    .clk_px(clk_px), .rst(rst), .en(en), .hs(hs), .vs(vs), .de(de),
    .px_x(px_x), .px_y(px_y), .sof(sof), .sol(sol), .running(running), .frame_cnt(frame_cnt)
  );
  always #5 clk_px = ~clk_px;
  function automatic bit in_rng(int c, int lo, int n);
    return c >= lo && c < lo + n;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  // Model: a frame is FR pixel slots; outputs after an edge describe the slot held before it.
  always @(posedge clk_px) begin
    if (rst || !m_run) begin
      e_hs <= !HP; e_vs <= !VP; e_de <= 0; e_x <= 0; e_y <= 0; e_sof <= 0; e_sol <= 0;
    end else begin
      e_hs  <= (m_pos % HT) < HS ? HP : !HP;
      e_vs  <= (m_pos / HT) < VS ? VP : !VP;
      e_de  <= in_rng(m_pos % HT, HS + HB, HA) && in_rng(m_pos / HT, VS + VB, VA);
      e_x   <= in_rng(m_pos % HT, HS + HB, HA) ? m_pos % HT - (HS + HB) : 0;
      e_y   <= in_rng(m_pos / HT, VS + VB, VA) ? m_pos / HT - (VS + VB) : 0;
      e_sof <= m_pos == 0;
      e_sol <= m_pos % HT == 0;
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    e_fc <= rst ? 0 : (m_run && m_pos == 0) ? (e_fc + 1) & 16'hFFFF : e_fc;
`endif
    m_run <= rst ? 1'b0 : m_run ? (m_pos == FR - 1 ? en : 1'b1) : en;
    e_run <= rst ? 1'b0 : m_run ? (m_pos == FR - 1 ? en : 1'b1) : en;
    m_pos <= (rst || !m_run || m_pos == FR - 1) ? 0 : m_pos + 1;
    chk_on <= 1;
  end
  always @(negedge clk_px)
    if (chk_on) begin
      chk("hs", hs, e_hs);
      chk("vs", vs, e_vs);
      chk("de", de, e_de);
      chk("px_x", px_x, e_x);
      chk("px_y", px_y, e_y);
      chk("sof", sof, e_sof);
      chk("sol", sol, e_sol);
      chk("running", running, e_run);
      chk("frame_cnt", frame_cnt, e_fc);
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, de_n, sol_n, hs_n, vs_n, lx, ly;
    bit drop;
    repeat (3) @(negedge clk_px);
    chk("rst_hs", hs, 1);
    chk("rst_vs", vs, 0);
    chk("rst_de", de, 0);
    chk("rst_run", running, 0);
    chk("rst_fc", frame_cnt, 0);
    rst = 0;
    repeat (2) @(negedge clk_px);
    en = 1;
    n = 0;
    do begin @(negedge clk_px); n++; end while (!sof && n < 10);
    chk("start_latency", n, 2);
    n = 0; de_n = 0; sol_n = 0; hs_n = 0; vs_n = 0; lx = -1; ly = -1;
    do begin
      @(negedge clk_px); n++;
      de_n += de; sol_n += sol; hs_n += (hs == HP); vs_n += (vs == VP);
      if (de) begin lx = px_x; ly = px_y; end
    end while (!sof && n < 400);
    chk("sof_period", n, 150);
    chk("de_cycles", de_n, 40);
    chk("sol_count", sol_n, 10);
    chk("hs_active", hs_n, 20);
    chk("vs_active", vs_n, 30);
    chk("last_px_x", lx, 7);
    chk("last_px_y", ly, 4);
    repeat (20) @(negedge clk_px);
    en = 0;
    n = 0;
    do begin @(negedge clk_px); n++; en = (n == 29); end while (running && n < 400);
    chk("stop_latency", n, 129);
    chk("stop_de", de, 0);
    en = 1;
    n = 0;
    do begin @(negedge clk_px); n++; end while (!sof && n < 10);
    chk("restart_latency", n, 2);
    repeat (30) @(negedge clk_px);
    en = 0;
    repeat (50) @(negedge clk_px);
    en = 1;
    n = 0; drop = 0;
    do begin @(negedge clk_px); n++; if (!running) drop = 1; end while (!sof && n < 300);
    chk("cancel_stop", drop, 0);
    repeat (60) @(negedge clk_px);
    rst = 1;
    @(negedge clk_px);
    chk("midrst_de", de, 0);
    chk("midrst_run", running, 0);
    chk("midrst_hs", hs, 1);
    chk("midrst_vs", vs, 0);
    chk("midrst_fc", frame_cnt, 0);
    rst = 0;
    n = 0;
    for (int k = 0; k < 3 && n < 1000; k++)
      do begin @(negedge clk_px); n++; end while (!sof && n < 1000);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("fc_three", frame_cnt, 3);
`else
    chk("fc_tied", frame_cnt, 0);
`endif
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_px);
      if ($urandom_range(0, 39) == 0) en = !en;
      rst = $urandom_range(0, 599) == 0;
    end
    rst = 0; en = 0;
    repeat (2) @(negedge clk_px);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
